// File: rtl/button_cond.sv
// Pushbutton conditioner: per-button two-flop synchronizer, debounce counter and
// registered press pulse. Define BUTTON_REPEAT_EN to add auto-repeat on REPEAT_MASK buttons.
module button_cond #(
    parameter int unsigned DB_LIMIT      = 20000,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000,
    parameter logic [5:0]  REPEAT_MASK   = 6'b000011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn_n_i,
    output logic [5:0] held_o,
    output logic [5:0] press_o
);

    localparam logic [19:0] DB_MAX = 20'(DB_LIMIT - 1);

    logic [5:0]  sync1;
    logic [5:0]  sync2;
    logic [19:0] db_cnt [6];
    logic [5:0]  db_flip;
    logic [5:0]  rise;
    logic [5:0]  fire;

    // A flip happens on the edge where the counter has already seen DB_LIMIT-1
    // differing samples and the current sample still differs.
    always_comb begin
        db_flip = '0;
        for (int i = 0; i < 6; i++) begin
            db_flip[i] = (sync2[i] != held_o[i]) && (db_cnt[i] == DB_MAX);
        end
        rise = db_flip & ~held_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= ~btn_n_i;
            sync2 <= sync1;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == held_o[i] || db_flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW      = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt [6];
    logic [5:0]    rep_first;
    logic [5:0]    rep_fire;

    // Repeats only while the button stays held through this edge; the edge
    // on which held_o clears never repeats.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 6; i++) begin
            rep_fire[i] = REPEAT_MASK[i] && held_o[i] && !db_flip[i] &&
                          (rep_cnt[i] == (rep_first[i] ? DELAY_LAST : PERIOD_LAST));
        end
        fire = rise | rep_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_first <= '0;
            for (int i = 0; i < 6; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (!REPEAT_MASK[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else if (rise[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b1;
                end else if (!held_o[i] || db_flip[i] || rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    always_comb begin
        fire = rise;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            held_o  <= '0;
            press_o <= '0;
        end else begin
            held_o  <= held_o ^ db_flip;
            press_o <= fire;
        end
    end

endmodule

// File: tb/tb_button_cond.sv
// Bench for button_cond: directed scenarios plus random presses, checked against
// a window/elapsed-time model of the debounce and repeat rules.
module tb_button_cond;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [5:0] RM = 6'b000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] btn_n_i;
    logic [5:0] held_o;
    logic [5:0] press_o;

    button_cond #(
        .DB_LIMIT(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(RM)
    ) dut (
        .clk(clk), .rst(rst), .btn_n_i(btn_n_i), .held_o(held_o), .press_o(press_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;

    // Model: raw_q holds the last two sampled levels (the synchronizer delay);
    // last_eq is the latest edge the seen level matched held; t0 the press edge.
    logic [5:0] raw_q[$];
    logic [5:0] m_held = '0;
    logic [5:0] m_press = '0;
    int last_eq[6];
    int t0[6];

    task automatic model_edge(input logic [5:0] raw_hi, input logic r);
        logic [5:0] seen;
        logic flip;
        int d;
        edge_n++;
        m_press = '0;
        if (r) begin
            raw_q = {6'h00, 6'h00};
            m_held = '0;
            for (int i = 0; i < 6; i++) begin
                last_eq[i] = edge_n;
                t0[i] = edge_n;
            end
        end else begin
            seen = raw_q[0];
            void'(raw_q.pop_front());
            raw_q.push_back(raw_hi);
            for (int i = 0; i < 6; i++) begin
                flip = 1'b0;
                if (seen[i] == m_held[i]) last_eq[i] = edge_n;
                else if (edge_n - last_eq[i] == DB) begin
                    flip = 1'b1;
                    last_eq[i] = edge_n;
                end
                if (flip) begin
                    m_held[i] = ~m_held[i];
                    if (m_held[i]) begin
                        m_press[i] = 1'b1;
                        t0[i] = edge_n;
                    end
                end
`ifdef BUTTON_REPEAT_EN
                else if (RM[i] && m_held[i]) begin
                    d = edge_n - t0[i];
                    if (d == RD || (d > RD && (d - RD) % RP == 0)) m_press[i] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, take the edge, update the model, compare 1 ns later.
    task automatic step(input logic [5:0] bn, input logic r);
        btn_n_i = bn;
        rst = r;
        @(posedge clk);
        model_edge(~bn, r);
        #1;
        check("model_held", held_o, m_held);
        check("model_press", press_o, m_press);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(6'h3f, 1'b0);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [5:0] cur;
    int pulses;

    initial begin
        btn_n_i = 6'h3f;
        rst = 1'b1;

        // Reset state
        step(6'h3f, 1'b1);
        step(6'b111110, 1'b1);
        check("reset_held", held_o, 6'h00);
        check("reset_press", press_o, 6'h00);

        // Stable press on up: held and pulse after edge 6, pulse gone after 7
        for (int k = 1; k <= 7; k++) begin
            step(6'b111110, 1'b0);
            if (k == 5) check("up_held_e5", held_o, 6'h00);
            if (k == 6) begin
                check("up_held_e6", held_o, 6'b000001);
                check("up_press_e6", press_o, 6'b000001);
            end
            if (k == 7) check("up_press_e7", press_o, 6'h00);
        end

        // Release: held clears on the 6th edge, never a pulse
        for (int k = 1; k <= 6; k++) begin
            step(6'h3f, 1'b0);
            check("release_press", press_o, 6'h00);
            if (k == 5) check("release_held_e5", held_o, 6'b000001);
            if (k == 6) check("release_held_e6", held_o, 6'h00);
        end

        // Bounce on left: one pulse, after edge 10
        step(6'h3f, 1'b1);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step((k == 4) ? 6'h3f : 6'b111011, 1'b0);
            if (press_o[2]) pulses++;
            if (k == 9) check("bounce_held_e9", held_o, 6'h00);
            if (k == 10) check("bounce_press_e10", press_o, 6'b000100);
        end
        check_int("bounce_pulse_count", pulses, 1);
        idle(8);

        // Enter and esc together
        step(6'h3f, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step(6'b001111, 1'b0);
            if (k == 6) check("dual_press_e6", press_o, 6'b110000);
            if (k == 7) check("dual_press_e7", press_o, 6'h00);
        end
        idle(8);

        // Reset mid-count, button held across reset release
        step(6'h3f, 1'b1);
        for (int k = 1; k <= 3; k++) step(6'b111110, 1'b0);
        step(6'b111110, 1'b1);
        check("midrst_held", held_o, 6'h00);
        check("midrst_press", press_o, 6'h00);
        for (int k = 1; k <= 6; k++) begin
            step(6'b111110, 1'b0);
            if (k == 5) check("midrst_held_e5", held_o, 6'h00);
            if (k == 6) begin
                check("midrst_held_e6", held_o, 6'b000001);
                check("midrst_press_e6", press_o, 6'b000001);
            end
        end
        idle(8);

        // Long hold on up: pulse edges depend on auto-repeat
        step(6'h3f, 1'b1);
`ifdef BUTTON_REPEAT_EN
        exp_q = {32'd6, 32'd16, 32'd19, 32'd22, 32'd25, 32'd28, 32'd31, 32'd34};
`else
        exp_q = {32'd6};
`endif
        for (int k = 1; k <= 34; k++) begin
            step(6'b111110, 1'b0);
            if (press_o[0]) got_q.push_back(32'(k));
        end
        check_int("hold_pulse_count", got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            check_int("hold_pulse_edge", int'(got_q[j]), int'(exp_q[j]));
        idle(8);

        // Random slow-changing buttons with occasional resets
        cur = 6'h3f;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
            step(cur, ($urandom_range(0, 149) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/button_cond.md
BUTTON_COND -- requirements
Module: button_cond

Interface
- REQ-001: Parameter DB_LIMIT, default 20000; consecutive cycles a synchronized level must differ from the debounced state before that state flips; legal range 2..2^20.
- REQ-002: Parameter REPEAT_DELAY, default 500000; cycles from the initial press pulse to the first auto-repeat pulse; used only with BUTTON_REPEAT_EN.
- REQ-003: Parameter REPEAT_PERIOD, default 100000; cycles between subsequent auto-repeat pulses; used only with BUTTON_REPEAT_EN.
- REQ-004: Parameter REPEAT_MASK, default 6'b000011; buttons eligible for auto-repeat (up, down); used only with BUTTON_REPEAT_EN.
- REQ-005: clk  input  1  single system clock; all state updates on the rising edge.
- REQ-006: rst  input  1  synchronous, active-high reset.
- REQ-007: btn_n_i  input  6  raw active-low pushbuttons, asynchronous to clk; bit0 up, bit1 down, bit2 left, bit3 right, bit4 enter, bit5 esc.
- REQ-008: held_o  output  6  debounced active-high level per button, registered.
- REQ-009: press_o  output  6  one-cycle active-high press pulse per button, registered; feeds the watch top's up/down/left/right/enter/esc controls.

Function
- REQ-010: Each bit shall pass through a two-flop synchronizer storing the inverted (active-high) level.
- REQ-011: Each button shall have an independent 20-bit debounce counter; no cross-button interaction.
- REQ-012: Synchronized level equal to held_o: the counter shall clear to 0.
- REQ-013: Level differs and counter < DB_LIMIT-1: the counter shall increment.
- REQ-014: Level differs and counter == DB_LIMIT-1: held_o shall toggle and the counter shall clear, on the same edge.
- REQ-015: A raw level held stable shall change held_o exactly DB_LIMIT+2 rising edges after the first edge that samples it.
- REQ-016: Any single-cycle return to the debounced level shall clear the counter and restart the full DB_LIMIT count.
- REQ-017: press_o[i] shall be 1 for exactly the one cycle in which held_o[i] first reads 1 after a 0-to-1 flip.
- REQ-018: A 1-to-0 flip of held_o shall produce no pulse.
- REQ-019: Simultaneous flips on several buttons shall produce pulses in the same cycle on every affected bit.

Reset
- REQ-020: With rst high at a rising edge, synchronizer flops, debounce counters, repeat counters, held_o and press_o shall all clear to 0 (released).
- REQ-021: Reset asserted mid-count shall discard the partial count; no pulse is emitted for that press.
- REQ-022: A button held across reset release shall be treated as a new press: held_o and press_o assert DB_LIMIT+2 edges after the first non-reset edge.

Configuration
- REQ-023: Macro BUTTON_REPEAT_EN shall enable auto-repeat; when undefined, the repeat counters and logic shall not be compiled and each press yields exactly one pulse.
- REQ-024: With BUTTON_REPEAT_EN, for each bit set in REPEAT_MASK, a repeat counter shall clear on every press_o pulse and count while held_o is 1.
- REQ-025: With BUTTON_REPEAT_EN, the first repeat pulse shall occur REPEAT_DELAY cycles after the initial pulse, then one pulse every REPEAT_PERIOD cycles.
- REQ-026: With BUTTON_REPEAT_EN, repeat pulses shall stop on the edge held_o clears; unmasked bits never repeat.

Verification (DB_LIMIT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- REQ-027: btn_n_i[0] driven low before edge 1 and held -> held_o[0]=1 and press_o[0]=1 after edge 6; press_o[0]=0 after edge 7.
- REQ-028: btn_n_i[2] low 3 cycles, high 1 cycle, then low steady from edge 5 -> exactly one press_o[2] pulse, after edge 10.
- REQ-029: Release of a debounced button -> held_o clears 6 edges after the release sample; press_o stays 0 throughout.
- REQ-030: btn_n_i[4] and btn_n_i[5] driven low on the same edge -> press_o = 6'b110000 for one cycle.
- REQ-031: rst pulsed at edge 4 of a press count -> all outputs 0; held_o asserts 6 edges after the first non-reset edge.
- REQ-032: up held 30 cycles -> with BUTTON_REPEAT_EN, pulses after edges 6, 16, 19, 22, 25, 28, 31, 34; without the macro, a single pulse after edge 6.
